demux_1n_hs: RTL and testbench
==============================

// Module: demux_1n_hs
// PURPOSE
//  Parametrised 1-to-N registered demultiplexer with valid/ready handshake; successor to the
//  combinational 1-to-8 enable demux. Steers one input word to one of N_OUT channels, either by
//  explicit select (addressed mode) or by an internal round-robin pointer (scan mode).
//  Sits between a single producer and N consumer channels; one-entry output holding register.
// PARAMETERS
//  DATA_W  8  payload width in bits
//  N_OUT   8  number of output channels, 2..256
//  SEL_W   3  select width; N_OUT <= 2**SEL_W (elaboration error otherwise)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous active-high reset
//  in_valid   in   1        producer word valid
//  in_ready   out  1        block can accept this cycle
//  in_data    in   DATA_W   payload
//  in_sel     in   SEL_W    destination channel (addressed mode only)
//  mode       in   1        0 = addressed, 1 = round-robin scan
//  out_valid  out  N_OUT    one-hot (or zero) channel valid
//  out_ready  in   N_OUT    per-channel consumer ready
//  out_data   out  DATA_W   shared payload bus, meaningful where out_valid set
//  rr_ptr     out  SEL_W    current round-robin pointer
//  sel_err    out  1        one-cycle pulse: out-of-range word dropped
//  drop_cnt   out  8        saturating count of dropped words
// BEHAVIOUR
//  - Reset (rst high at clk edge): out_valid=0, out_data=0, rr_ptr=0, sel_err=0, drop_cnt=0,
//    holding register empty. in_ready is 0 in any cycle where rst is high.
//  - Holding register: held flag, chan index, data. out_valid = held ? (1<<chan) : 0.
//  - in_ready = !rst & (!held | out_ready[chan]) (combinational; allows back-to-back transfer).
//  - Accept = in_valid & in_ready. Latency: accepted word appears on out_valid/out_data the next cycle.
//  - Release = held & out_ready[chan]. Release without accept clears held; release with accept
//    reloads register same edge (full throughput, one word per cycle sustained).
//  - out_ready of non-selected channels is ignored; held word, chan and data stay stable until released.
//  - Destination at accept: mode=0 -> in_sel; mode=1 -> rr_ptr (in_sel ignored). mode sampled only at accept.
//  - rr_ptr increments on every accept in mode=1, wraps N_OUT-1 -> 0; unchanged in mode=0
//    and unchanged by mode switches.
//  - Out-of-range: mode=0 and in_sel >= N_OUT at accept -> word dropped (held not set by it;
//    if a release occurs the same edge, held clears), sel_err=1 next cycle for exactly one cycle,
//    drop_cnt += 1 saturating at 255. Cannot occur in mode=1.
//  - sel_err is 0 in all other cycles; out_data retains last loaded value when held=0.
//  - Reset mid-transfer discards the held word with no release and no drop count.
// TESTING
//  1 Addressed: mode=0, sel=5, data=8'hA5, out_ready=all 1 -> next cycle out_valid=8'b0010_0000,
//    out_data=A5, cleared following cycle.
//  2 Backpressure: hold sel=2 word with out_ready[2]=0 for 4 cycles, toggle other out_ready ->
//    out_valid/out_data stable, in_ready=0; raise out_ready[2] -> in_ready=1 same cycle.
//  3 Streaming: 16 words, mode=1, all ready -> one word/cycle, channels 0..7,0..7, rr_ptr back to 0.
//  4 Out-of-range: N_OUT=6, SEL_W=3, mode=0, sel=7 -> no out_valid, sel_err pulse 1 cycle,
//    drop_cnt=1; 300 such words -> drop_cnt=255.
//  5 Reset mid-hold: word held on ch3, assert rst 1 cycle -> out_valid=0, rr_ptr=0, drop_cnt=0,
//    in_ready=0 during rst, 1 after.
//  6 Mode switch: mode=1 accept 3 words (rr_ptr=3), mode=0 accept sel=0, mode=1 -> next word to ch3.

Source files
------------

// File: rtl/demux_1n_hs.sv
// Registered 1-to-N demultiplexer with valid/ready handshake and a one-entry holding register.
// Destination is either the explicit select (addressed mode) or an internal round-robin pointer.
module demux_1n_hs #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              mode,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  rr_ptr,
    output logic              sel_err,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned      N_PAD   = 1 << SEL_W;
    localparam logic [SEL_W:0]   N_OUT_L = (SEL_W + 1)'(N_OUT);
    localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(N_OUT - 1);

    generate
        if (N_OUT < 2 || N_OUT > 256 || N_OUT > N_PAD) begin : g_bad_param
            $error("demux_1n_hs: N_OUT must be 2..256 and fit in SEL_W bits");
        end
    endgenerate

    logic              held_q, held_d;
    logic [SEL_W-1:0]  chan_q, chan_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N_OUT-1:0]  valid_q, valid_d;
    logic [SEL_W-1:0]  rr_q, rr_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic [N_PAD-1:0]  ready_pad;
    logic              release_c;
    logic              accept_c;
    logic              in_range_c;
    logic              load_c;
    logic              drop_c;
    logic [SEL_W-1:0]  dest_c;

    // Handshake decode; padding lets a full-width select index the ready vector.
    always_comb begin
        ready_pad  = N_PAD'(out_ready);
        release_c  = held_q & ready_pad[chan_q];
        in_ready   = !rst & (!held_q | release_c);
        accept_c   = in_valid & in_ready;
        dest_c     = mode ? rr_q : in_sel;
        in_range_c = mode | ({1'b0, in_sel} < N_OUT_L);
        load_c     = accept_c & in_range_c;
        drop_c     = accept_c & !in_range_c;
    end

    // Next-state: holding register, pointer and drop bookkeeping.
    always_comb begin
        held_d  = held_q;
        chan_d  = chan_q;
        data_d  = data_q;
        valid_d = valid_q;
        rr_d    = rr_q;
        err_d   = drop_c;
        cnt_d   = cnt_q;

        if (load_c) begin
            held_d  = 1'b1;
            chan_d  = dest_c;
            data_d  = in_data;
            valid_d = N_OUT'(1) << dest_c;
        end else if (release_c) begin
            held_d  = 1'b0;
            valid_d = '0;
        end

        if (accept_c && mode) begin
            rr_d = (rr_q == RR_LAST) ? '0 : rr_q + SEL_W'(1);
        end

        if (drop_c && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q  <= 1'b0;
            chan_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            held_q  <= held_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign rr_ptr    = rr_q;
    assign sel_err   = err_q;
    assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1n_hs.sv
// Bench for demux_1n_hs: scoreboard of expected deliveries on an 8-channel instance plus
// directed checks on a 6-channel instance for out-of-range selects.
module tb_demux_1n_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       mode;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [7:0] out_data;
    logic [2:0] rr_ptr;
    logic       sel_err;
    logic [7:0] drop_cnt;

    logic       b_valid;
    logic       b_in_ready;
    logic [5:0] b_out_valid;
    logic [5:0] b_out_ready;
    logic [7:0] b_out_data;
    logic [2:0] b_rr_ptr;
    logic       b_sel_err;
    logic [7:0] b_drop;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    logic [2:0]  tb_rr = 3'd0;

    always #5 clk = ~clk;

    demux_1n_hs #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rr_ptr(rr_ptr), .sel_err(sel_err), .drop_cnt(drop_cnt)
    );

    demux_1n_hs #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_sel(in_sel), .mode(mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .rr_ptr(b_rr_ptr), .sel_err(b_sel_err), .drop_cnt(b_drop)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word on instance A; record the expected delivery when push is set.
    task automatic send(input logic m, input logic [2:0] sel, input logic [7:0] d, input logic push);
        int waited;
        logic [2:0] ch;
        mode     = m;
        in_sel   = sel;
        in_data  = d;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            step();
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low for data %0h", d);
        end else begin
            ch = m ? tb_rr : sel;
            if (m) tb_rr = (tb_rr == 3'd7) ? 3'd0 : tb_rr + 3'd1;
            if (push) exp_q.push_back({5'd0, ch, d});
        end
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: each release on instance A must match the oldest expected word.
    always @(negedge clk) begin
        logic [7:0]  rel;
        logic [2:0]  ch;
        logic [15:0] e;
        if (!rst) begin
            chk("onehot0", 32'($onehot0(out_valid)), 32'd1);
            rel = out_valid & out_ready;
            if (rel != 8'd0) begin
                ch = 3'd0;
                for (int i = 0; i < 8; i++) if (rel[i]) ch = 3'(i);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL deliver_unexpected: chan %0d data %0h", ch, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_chan", 32'(ch), 32'(e[10:8]));
                    chk("deliver_data", 32'(out_data), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_sel = 3'd0; mode = 1'b0;
        out_ready = 8'hFF; b_valid = 1'b0; b_out_ready = 6'h3F;
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        rst = 1'b0;

        // Addressed single word
        send(1'b0, 3'd5, 8'hA5, 1'b1);
        @(negedge clk);
        chk("addr_out_valid", 32'(out_valid), 32'h20);
        chk("addr_out_data", 32'(out_data), 32'hA5);
        step();
        @(negedge clk);
        chk("addr_cleared", 32'(out_valid), 32'h0);
        chk("addr_data_kept", 32'(out_data), 32'hA5);
        step();

        // Backpressure on channel 2 while other readies toggle
        out_ready = 8'hFB;
        send(1'b0, 3'd2, 8'h3C, 1'b1);
        in_valid = 1'b1; in_sel = 3'd1; in_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            out_ready = (i % 2 == 0) ? 8'h00 : 8'hFB;
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'h04);
            chk("bp_out_data", 32'(out_data), 32'h3C);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            step();
        end
        out_ready = 8'hFF;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        exp_q.push_back({8'h01, 8'h77});
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid), 32'h02);
        step();

        // Round-robin streaming, one word per cycle
        mode = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'h10 + 8'(i);
            @(negedge clk);
            chk("stream_ready", 32'(in_ready), 32'h1);
            exp_q.push_back({5'd0, tb_rr, in_data});
            tb_rr = (tb_rr == 3'd7) ? 3'd0 : tb_rr + 3'd1;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_rr_wrap", 32'(rr_ptr), 32'h0);
        chk("stream_last_ch7", 32'(out_valid), 32'h80);
        step();

        // Mode switch keeps the pointer
        send(1'b1, 3'd0, 8'h61, 1'b1);
        send(1'b1, 3'd0, 8'h62, 1'b1);
        send(1'b1, 3'd0, 8'h63, 1'b1);
        @(negedge clk);
        chk("msw_rr3", 32'(rr_ptr), 32'h3);
        step();
        send(1'b0, 3'd0, 8'h64, 1'b1);
        @(negedge clk);
        chk("msw_addr_ch0", 32'(out_valid), 32'h01);
        chk("msw_rr_kept", 32'(rr_ptr), 32'h3);
        step();
        send(1'b1, 3'd5, 8'h65, 1'b1);
        @(negedge clk);
        chk("msw_scan_ch3", 32'(out_valid), 32'h08);
        chk("msw_rr4", 32'(rr_ptr), 32'h4);
        step();

        // Out-of-range on the 6-channel instance
        mode = 1'b0; in_sel = 3'd6; in_data = 8'hEE; b_valid = 1'b1;
        @(negedge clk);
        chk("oor_in_ready", 32'(b_in_ready), 32'h1);
        step();
        b_valid = 1'b0;
        @(negedge clk);
        chk("oor_sel_err", 32'(b_sel_err), 32'h1);
        chk("oor_no_valid", 32'(b_out_valid), 32'h0);
        chk("oor_drop1", 32'(b_drop), 32'h1);
        step();
        @(negedge clk);
        chk("oor_err_pulse", 32'(b_sel_err), 32'h0);
        in_sel = 3'd5; in_data = 8'h55; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        @(negedge clk);
        chk("oor_edge_valid", 32'(b_out_valid), 32'h20);
        chk("oor_edge_data", 32'(b_out_data), 32'h55);
        chk("oor_edge_err", 32'(b_sel_err), 32'h0);
        chk("oor_edge_drop", 32'(b_drop), 32'h1);
        step();
        in_sel = 3'd7; b_valid = 1'b1;
        repeat (300) step();
        b_valid = 1'b0;
        @(negedge clk);
        chk("oor_saturate", 32'(b_drop), 32'hFF);
        chk("oor_sat_no_valid", 32'(b_out_valid), 32'h0);
        step();

        // Reset while a word is held on channel 3
        out_ready = 8'hF7;
        send(1'b0, 3'd3, 8'h5A, 1'b0);
        @(negedge clk);
        chk("rmid_held", 32'(out_valid), 32'h08);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_a_ready", 32'(in_ready), 32'h0);
        chk("rmid_b_ready", 32'(b_in_ready), 32'h0);
        step();
        rst = 1'b0;
        tb_rr = 3'd0;
        @(negedge clk);
        chk("rmid_out_valid", 32'(out_valid), 32'h0);
        chk("rmid_rr_ptr", 32'(rr_ptr), 32'h0);
        chk("rmid_b_drop", 32'(b_drop), 32'h0);
        chk("rmid_in_ready", 32'(in_ready), 32'h1);
        step();
        out_ready = 8'hFF;
        step();
        step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
